// File: rtl/synth_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : synth_param_pkg                                              |
// | Description : Shared definitions for the synth parameter bank: slot index  |
// |               constants, the auto-repeat state encoding and the default /  |
// |               upper-bound vectors used by the synth's parameter bank.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package synth_param_pkg;

    // Slot indices within the parameter bank
    localparam int PRM_OCTAVE  = 0;
    localparam int PRM_AMP     = 1;
    localparam int PRM_ATTACK  = 2;
    localparam int PRM_DECAY   = 3;
    localparam int PRM_SUSTAIN = 4;
    localparam int PRM_RELEASE = 5;

    localparam int SYNTH_NUM_PARAMS = 6;
    localparam int SYNTH_WIDTH      = 8;

    // Auto-repeat state machine encoding
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Reset values, highest slot first (slot i at bits [i*8 +: 8])
    localparam logic [SYNTH_NUM_PARAMS*SYNTH_WIDTH-1:0] SYNTH_DEFAULTS = {
        8'd20,   // release
        8'd128,  // sustain
        8'd50,   // decay
        8'd10,   // attack
        8'd100,  // amp
        8'd4     // octave
    };

    // Per-slot upper bounds, highest slot first
    localparam logic [SYNTH_NUM_PARAMS*SYNTH_WIDTH-1:0] SYNTH_MAXV = {
        8'd255,  // release
        8'd255,  // sustain
        8'd255,  // decay
        8'd255,  // attack
        8'd200,  // amp
        8'd7     // octave
    };

endpackage
`default_nettype wire

// File: rtl/param_step_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : param_step_sat                                               |
// | Description : Saturating single step of one parameter value. Increments   |
// |               clamp at max, decrements clamp at zero; up and down together |
// |               (or neither) pass the value through unchanged.               |
// | Ports       : value      - current value                                   |
// |               max        - upper bound for this slot                       |
// |               up / down  - step direction requests                         |
// |               next_value - stepped value                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module param_step_sat
    import synth_param_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] max,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] next_value
);

    localparam logic [WIDTH:0] c_step = (WIDTH+1)'(STEP);

    // One extra bit so the sum can never wrap before the clamp
    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, value} + c_step;

    always_comb begin
        next_value = value;
        if (up && !down) begin
            next_value = (w_sum > {1'b0, max}) ? max : w_sum[WIDTH-1:0];
        end else if (down && !up) begin
            next_value = ({1'b0, value} >= c_step) ? (value - c_step[WIDTH-1:0]) : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/param_bank_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : param_bank_ctrl                                              |
// | Description : Bank of NUM_PARAMS editable synth parameters. Front-panel    |
// |               inc/dec keys step the selected slot on their rising edge     |
// |               with saturation at 0 and MAXV; load writes an absolute       |
// |               (clamped) value. Optional auto-repeat while a key is held    |
// |               is enabled by defining the macro PARAM_AUTOREPEAT_EN.        |
// | Ports       : clk, reset (sync, active-low)                                |
// |               sel, inc, dec, load, load_val - edit controls                |
// |               values      - all slots, flattened, registered               |
// |               changed     - one-cycle pulse when a slot value changes      |
// |               changed_idx - slot that changed                              |
// |               sel_err     - registered, high while sel >= NUM_PARAMS       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module param_bank_ctrl
    import synth_param_pkg::*;
#(
    parameter int                          NUM_PARAMS   = 6,
    parameter int                          WIDTH        = 8,
    parameter int                          STEP         = 1,
    parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS     = '0,
    parameter logic [NUM_PARAMS*WIDTH-1:0] MAXV         = '1,
    parameter int                          REPEAT_DELAY = 25_000_000,
    parameter int                          REPEAT_RATE  = 5_000_000,
    localparam int                         SEL_W        = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        inc,
    input  logic                        dec,
    input  logic                        load,
    input  logic [WIDTH-1:0]            load_val,
    output logic [NUM_PARAMS*WIDTH-1:0] values,
    output logic                        changed,
    output logic [SEL_W-1:0]            changed_idx,
    output logic                        sel_err
);

    localparam logic [SEL_W:0] c_num_params = (SEL_W+1)'(NUM_PARAMS);

    logic [WIDTH-1:0] r_slot [NUM_PARAMS];
    logic             r_inc_q;
    logic             r_dec_q;
    logic             r_changed;
    logic [SEL_W-1:0] r_changed_idx;
    logic             r_sel_err;

    logic             w_sel_ok;
    logic [SEL_W-1:0] w_idx;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_step_nxt;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_new;
    logic             w_write;
    logic             w_edge_inc;
    logic             w_edge_dec;
    logic             w_step_up;
    logic             w_step_dn;
    logic             w_rep_step;
    logic             w_rep_up;

    // Out-of-range selects read slot 0 but never write (w_sel_ok gates writes)
    assign w_sel_ok = ({1'b0, sel} < c_num_params);
    assign w_idx    = w_sel_ok ? sel : '0;
    assign w_cur    = r_slot[w_idx];
    assign w_max    = MAXV[w_idx*WIDTH +: WIDTH];

    // Rising edges; a simultaneous press of the other key cancels the step
    assign w_edge_inc = inc & ~r_inc_q & ~dec;
    assign w_edge_dec = dec & ~r_dec_q & ~inc;

    assign w_step_up = w_edge_inc | (w_rep_step &  w_rep_up);
    assign w_step_dn = w_edge_dec | (w_rep_step & ~w_rep_up);

    assign w_load_clamped = (load_val > w_max) ? w_max : load_val;

    param_step_sat #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .value      (w_cur),
        .max        (w_max),
        .up         (w_step_up),
        .down       (w_step_dn),
        .next_value (w_step_nxt)
    );

    // Load wins over any step in the same cycle
    always_comb begin
        w_write = 1'b0;
        w_new   = w_cur;
        if (w_sel_ok) begin
            if (load) begin
                w_write = 1'b1;
                w_new   = w_load_clamped;
            end else if (w_step_up || w_step_dn) begin
                w_write = 1'b1;
                w_new   = w_step_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                r_slot[i] <= DEFAULTS[i*WIDTH +: WIDTH];
            end
            // Keys held through reset release must not look like a fresh press
            r_inc_q       <= 1'b1;
            r_dec_q       <= 1'b1;
            r_changed     <= 1'b0;
            r_changed_idx <= '0;
            r_sel_err     <= 1'b0;
        end else begin
            r_inc_q   <= inc;
            r_dec_q   <= dec;
            r_sel_err <= ~w_sel_ok;
            r_changed <= w_write && (w_new != w_cur);
            if (w_write) begin
                r_slot[w_idx] <= w_new;
            end
            if (w_write && (w_new != w_cur)) begin
                r_changed_idx <= w_idx;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_pack
            assign values[g*WIDTH +: WIDTH] = r_slot[g];
        end
    endgenerate

    assign changed     = r_changed;
    assign changed_idx = r_changed_idx;
    assign sel_err     = r_sel_err;

`ifdef PARAM_AUTOREPEAT_EN
    localparam int c_cnt_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_cnt_w   = (c_cnt_max > 0) ? $clog2(c_cnt_max + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_delay = c_cnt_w'(REPEAT_DELAY);
    localparam logic [c_cnt_w-1:0] c_rate  = c_cnt_w'(REPEAT_RATE);

    rpt_state_t       r_state;
    rpt_state_t       w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic             r_dir_up;
    logic             w_dir_nxt;
    logic [SEL_W-1:0] r_sel;
    logic             w_held;
    logic             w_abort;

    // The key that started the hold must stay down, alone, on the same slot
    assign w_held  = r_dir_up ? inc : dec;
    assign w_abort = load | (inc & dec) | (sel != r_sel) | ~w_held | ~w_sel_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= RPT_IDLE;
            r_cnt    <= '0;
            r_dir_up <= 1'b0;
            r_sel    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir_up <= w_dir_nxt;
            r_sel    <= sel;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir_up;
        w_rep_step  = 1'b0;
        case (r_state)
            RPT_IDLE: begin
                w_cnt_nxt = '0;
                if (w_sel_ok && !load && (w_edge_inc || w_edge_dec)) begin
                    w_state_nxt = RPT_DELAY;
                    w_cnt_nxt   = c_delay;
                    w_dir_nxt   = w_edge_inc;
                end
            end
            RPT_DELAY, RPT_REPEAT: begin
                if (w_abort) begin
                    w_state_nxt = RPT_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_rep_step  = 1'b1;
                    w_cnt_nxt   = c_rate;
                    w_state_nxt = RPT_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = RPT_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_rep_up = r_dir_up;
`else
    assign w_rep_step = 1'b0;
    assign w_rep_up   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_bank_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_param_bank_ctrl                                           |
// | Description : Scoreboard bench for param_bank_ctrl. Stimulus pushes the    |
// |               hand-computed bank contents expected after each clock; a     |
// |               monitor pops and compares on the opposite clock edge.        |
// |               Auto-repeat checks follow PARAM_AUTOREPEAT_EN.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_param_bank_ctrl;
    import synth_param_pkg::*;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  sel = '0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_val = '0;
    logic [47:0] values;
    logic        changed;
    logic [2:0]  changed_idx;
    logic        sel_err;

    param_bank_ctrl #(
        .NUM_PARAMS   (6),
        .WIDTH        (8),
        .STEP         (1),
        .DEFAULTS     (SYNTH_DEFAULTS),
        .MAXV         (SYNTH_MAXV),
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .inc         (inc),
        .dec         (dec),
        .load        (load),
        .load_val    (load_val),
        .values      (values),
        .changed     (changed),
        .changed_idx (changed_idx),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [47:0] vals;
        logic        chg;
        logic        chk_idx;
        logic [2:0]  idx;
        logic        serr;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mdl [6];
    logic [7:0]  rpt_val [12];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic set_defaults();
        mdl[0] = 8'd4;  mdl[1] = 8'd100; mdl[2] = 8'd10;
        mdl[3] = 8'd50; mdl[4] = 8'd128; mdl[5] = 8'd20;
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic vec(input logic rst_n, input logic i_inc, input logic i_dec,
                       input logic i_ld, input logic [7:0] lv, input logic [2:0] s,
                       input string nm, input logic chg, input logic [2:0] idx,
                       input logic serr);
        exp_t e;
        @(negedge clk);
        reset    = rst_n;
        inc      = i_inc;
        dec      = i_dec;
        load     = i_ld;
        load_val = lv;
        sel      = s;
        e.cyc     = cyc + 1;
        e.name    = nm;
        for (int i = 0; i < 6; i++) e.vals[i*8 +: 8] = mdl[i];
        e.chg     = chg;
        e.chk_idx = chg | ~rst_n;
        e.idx     = idx;
        e.serr    = serr;
        q.push_back(e);
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc || values !== e.vals || changed !== e.chg ||
                sel_err !== e.serr || (e.chk_idx && changed_idx !== e.idx)) begin
                n_err++;
                $display("FAIL %s: got values=%h changed=%b idx=%0d sel_err=%b, want values=%h changed=%b idx=%0d sel_err=%b (cycle %0d/%0d)",
                         e.name, values, changed, changed_idx, sel_err,
                         e.vals, e.chg, e.idx, e.serr, cyc, e.cyc);
            end
        end
    end

    initial begin
`ifdef PARAM_AUTOREPEAT_EN
        rpt_val = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd4};
`else
        rpt_val = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
`endif
        set_defaults();

        // Reset state and release
        vec(L, L, L, L, 8'd0, 3'd0, "reset_state",   L, 3'd0, L);
        vec(L, L, L, L, 8'd0, 3'd0, "reset_hold",    L, 3'd0, L);
        vec(H, L, L, L, 8'd0, 3'd0, "reset_release", L, 3'd0, L);

        // Amp: load 10, then one inc pulse -> 11
        mdl[1] = 8'd10;
        vec(H, L, L, H, 8'd10, 3'd1, "load_amp10", H, 3'd1, L);
        vec(H, L, L, L, 8'd0,  3'd1, "idle_a",     L, 3'd0, L);
        mdl[1] = 8'd11;
        vec(H, H, L, L, 8'd0,  3'd1, "inc_amp",     H, 3'd1, L);
        vec(H, L, L, L, 8'd0,  3'd1, "inc_release", L, 3'd0, L);

        // Octave saturates at 7
        mdl[0] = 8'd7;
        vec(H, L, L, H, 8'd7, 3'd0, "load_oct7",       H, 3'd0, L);
        vec(H, L, L, L, 8'd0, 3'd0, "idle_b",          L, 3'd0, L);
        vec(H, H, L, L, 8'd0, 3'd0, "inc_at_max",      L, 3'd0, L);
        vec(H, L, L, L, 8'd0, 3'd0, "inc_max_release", L, 3'd0, L);

        // Decay floors at 0
        mdl[3] = 8'd0;
        vec(H, L, L, H, 8'd0, 3'd3, "load_decay0",      H, 3'd3, L);
        vec(H, L, L, L, 8'd0, 3'd3, "idle_c",           L, 3'd0, L);
        vec(H, L, H, L, 8'd0, 3'd3, "dec_at_zero",      L, 3'd0, L);
        vec(H, L, L, L, 8'd0, 3'd3, "dec_zero_release", L, 3'd0, L);

        // Attack = 50, inc and dec rise together -> no step
        mdl[2] = 8'd50;
        vec(H, L, L, H, 8'd50, 3'd2, "load_attack50", H, 3'd2, L);
        vec(H, L, L, L, 8'd0,  3'd2, "idle_d",        L, 3'd0, L);
        vec(H, H, H, L, 8'd0,  3'd2, "inc_dec_both",  L, 3'd0, L);
        vec(H, L, L, L, 8'd0,  3'd2, "both_release",  L, 3'd0, L);

        // Load 255 into amp (max 200) while inc rises: clamp, no step
        mdl[1] = 8'd200;
        vec(H, H, L, H, 8'd255, 3'd1, "load_clamp_over_inc", H, 3'd1, L);
        vec(H, L, L, L, 8'd0,   3'd1, "after_load",          L, 3'd0, L);
        mdl[1] = 8'd199;
        vec(H, L, H, L, 8'd0,   3'd1, "dec_amp",             H, 3'd1, L);
        vec(H, L, L, L, 8'd0,   3'd1, "dec_release",         L, 3'd0, L);

        // Out-of-range select: inputs ignored, sel_err raised
        vec(H, H, L, L, 8'd0, 3'd7, "sel_err_inc",  L, 3'd0, H);
        vec(H, L, L, H, 8'd9, 3'd7, "sel_err_load", L, 3'd0, H);
        vec(H, L, L, L, 8'd0, 3'd1, "sel_ok_again", L, 3'd0, L);

        // Release slot: 0, then hold inc (auto-repeat when compiled in)
        mdl[5] = 8'd0;
        vec(H, L, L, H, 8'd0, 3'd5, "load_rel0", H, 3'd5, L);
        vec(H, L, L, L, 8'd0, 3'd5, "idle_e",    L, 3'd0, L);
        mdl[5] = rpt_val[0];
        vec(H, H, L, L, 8'd0, 3'd5, "hold_edge", H, 3'd5, L);
        for (int j = 1; j <= 11; j++) begin
            logic stepped;
            stepped = (rpt_val[j] != rpt_val[j-1]);
            mdl[5]  = rpt_val[j];
            vec(H, H, L, L, 8'd0, 3'd5, $sformatf("hold_repeat_%0d", j), stepped, 3'd5, L);
        end
        // Move to another slot while still holding: repeating stops
        for (int j = 0; j < 4; j++) begin
            vec(H, H, L, L, 8'd0, 3'd4, $sformatf("hold_sel_switch_%0d", j), L, 3'd0, L);
        end
        vec(H, L, L, L, 8'd0, 3'd4, "hold_released", L, 3'd0, L);

        // Reset with inc held: defaults return, no step on release
        set_defaults();
        vec(L, H, L, L, 8'd0, 3'd1, "reset_inc_held",   L, 3'd0, L);
        vec(L, H, L, L, 8'd0, 3'd1, "reset_inc_held2",  L, 3'd0, L);
        vec(H, H, L, L, 8'd0, 3'd1, "release_inc_held", L, 3'd0, L);
        vec(H, H, L, L, 8'd0, 3'd1, "inc_still_held",   L, 3'd0, L);
        vec(H, L, L, L, 8'd0, 3'd1, "inc_dropped",      L, 3'd0, L);

        // Let the monitor drain the queue within a bounded number of cycles
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: never checked (timeout), want values=%h", e.name, e.vals);
        end

        if (values !== SYNTH_DEFAULTS) begin
            n_err++;
            $display("FAIL final_defaults: got values=%h, want %h", values, SYNTH_DEFAULTS);
        end
        if (changed !== 1'b0 || sel_err !== 1'b0) begin
            n_err++;
            $display("FAIL final_flags: changed=%b sel_err=%b", changed, sel_err);
        end
        if (n_vec < 12) begin
            n_err++;
            $display("FAIL too few vectors checked: %0d", n_vec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_bank_ctrl.md
PARAM_BANK_CTRL -- requirements
Module: param_bank_ctrl

Interface
REQ-001 Parameter: NUM_PARAMS, 6, number of stored synth parameters; legal range 1..16.
REQ-002 Parameter: WIDTH, 8, bits per parameter; legal range 2..31.
REQ-003 Parameter: STEP, 1, amount added or removed per step.
REQ-004 Parameter: DEFAULTS, all zero, flattened NUM_PARAMS*WIDTH reset values; slot i is bits [i*WIDTH +: WIDTH].
REQ-005 Parameter: MAXV, all ones, flattened per-slot upper bound; minimum is 0 for every slot.
REQ-006 Parameter: REPEAT_DELAY, 25_000_000, cycles of hold before the first auto-repeat step.
REQ-007 Parameter: REPEAT_RATE, 5_000_000, cycles between later auto-repeat steps.
REQ-008 Port: clk  input  1  system clock.
REQ-009 Port: reset  input  1  synchronous, active-low reset.
REQ-010 Port: sel  input  SEL_W (= max(1, clog2(NUM_PARAMS)))  index of the parameter being edited.
REQ-011 Port: inc  input  1  increment request, level (key held).
REQ-012 Port: dec  input  1  decrement request, level (key held).
REQ-013 Port: load  input  1  single-cycle absolute write to slot sel.
REQ-014 Port: load_val  input  WIDTH  value for load.
REQ-015 Port: values  output  NUM_PARAMS*WIDTH  all stored parameters, flattened, registered.
REQ-016 Port: changed  output  1  one-cycle pulse when any stored value changes.
REQ-017 Port: changed_idx  output  SEL_W  slot that changed; valid while changed=1.
REQ-018 Port: sel_err  output  1  registered; high while sel >= NUM_PARAMS.

Function
REQ-019 A step SHALL be triggered by a rising edge of inc or dec: input high this cycle and low in the registered copy. The new value SHALL be visible on values one cycle after the edge is sampled.
REQ-020 An increment SHALL produce min(v+STEP, MAXV[i]), computed at WIDTH+1 bits with no wrap-around.
REQ-021 A decrement SHALL produce v-STEP when v >= STEP, otherwise 0.
REQ-022 If inc and dec are both high in the same cycle, no step SHALL occur and the auto-repeat FSM SHALL return to IDLE.
REQ-023 load SHALL take priority over inc, dec and auto-repeat in the same cycle; the stored value SHALL be min(load_val, MAXV[sel]).
REQ-024 When sel >= NUM_PARAMS, load, inc and dec SHALL be ignored and sel_err SHALL be 1.
REQ-025 Only slot sel SHALL be modified in a given cycle; all other slots SHALL hold their values.
REQ-026 changed SHALL pulse only when the stored value actually differs, so a step at a saturated bound SHALL give changed=0.
REQ-027 Auto-repeat FSM states:
  - IDLE: on a rising edge of inc or dec, go to DELAY and load the counter with REPEAT_DELAY.
  - DELAY: count down; at 0, apply one step, reload with REPEAT_RATE, go to REPEAT.
  - REPEAT: at 0, apply one step and reload with REPEAT_RATE.
REQ-028 Releasing the held input, pressing both inputs, changing sel, or a load SHALL return the FSM to IDLE in the next cycle with no step.

Reset
REQ-029 While reset=0 at a clock edge: values = DEFAULTS, changed=0, changed_idx=0, sel_err=0, FSM IDLE, counter 0.
REQ-030 The registered copies of inc and dec SHALL reset to 1, so a key held through reset release produces no step.

Configuration
REQ-031 Macro PARAM_AUTOREPEAT_EN: when defined, the FSM and counter of REQ-027/028 are compiled in.
REQ-032 Without the macro, only edge-triggered steps and load exist, and REPEAT_DELAY and REPEAT_RATE are unused.

Structure
REQ-033 Package synth_param_pkg SHALL hold:
  - slot index constants: PRM_OCTAVE=0, PRM_AMP=1, PRM_ATTACK=2, PRM_DECAY=3, PRM_SUSTAIN=4, PRM_RELEASE=5;
  - the repeat FSM state enum;
  - default DEFAULTS/MAXV vectors for the synth (octave max 7, default 4).
REQ-034 The saturating step SHALL live in one sub-module, param_step_sat (inputs value, max, up, down; output next value).

Verification
REQ-035 WIDTH=8, STEP=1, slot 1 = 10: one inc pulse -> values slot 1 = 11 next cycle, changed=1, changed_idx=1.
REQ-036 Slot 0 with MAXV=7 at 7: inc pulse -> stays 7, changed=0. Slot 3 at 0: dec pulse -> stays 0, changed=0.
REQ-037 inc and dec rising in the same cycle on slot 2 = 50 -> no change, changed=0.
REQ-038 load_val=255 to a slot with MAXV=200 while inc is also rising -> slot = 200, no step applied.
REQ-039 PARAM_AUTOREPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, inc held 11 cycles from value 0 -> value 1 at the edge step, 2 at +5 cycles, 3 at +8, 4 at +11. Switching sel mid-hold stops repeating.
REQ-040 NUM_PARAMS=6, sel=7, inc pulse -> sel_err=1, all values unchanged. Then reset with inc held high -> DEFAULTS restored, and no step after release.
